seq_alu: RTL

- Registered ALU stage directly downstream of the control unit.
- Consumes iA, iB and opcode on a start pulse. Returns outrest and outflag with a done pulse.
- Single-cycle logic and arithmetic ops, plus iterative multiply/divide (shift-add / restoring) taking WIDTH extra cycles.
- Results and flags hold until the next completed operation, so the control unit can show them on LEDs.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/seq_muldiv_core.sv | 65 ++++++
 rtl/seq_alu.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for seq_alu and the control unit.
// SEQ_ALU_MULDIV_EN enables the iterative MUL/DIV/MOD opcodes.
package alu_pkg;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_AND     = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_NOT     = 4'd5;
  localparam logic [3:0] OP_SHL     = 4'd6;
  localparam logic [3:0] OP_SHR     = 4'd7;
  localparam logic [3:0] OP_MUL     = 4'd8;
  localparam logic [3:0] OP_DIV     = 4'd9;
  localparam logic [3:0] OP_MOD     = 4'd10;
  localparam logic [3:0] OP_INC     = 4'd11;
  localparam logic [3:0] OP_DEC     = 4'd12;
  localparam logic [3:0] OP_PASSA   = 4'd13;
  localparam logic [3:0] OP_PASSB   = 4'd14;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int FLG_E = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative datapath: shift-add multiply and restoring divide sharing one hi/lo register pair.
// Built only when SEQ_ALU_MULDIV_EN is defined; WIDTH steps per operation.
module seq_muldiv_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             div_q;
  logic [WIDTH:0]   add_s, rem_s, rem_d;

  // MUL: hi accumulates partial products, lo shifts out multiplier bits.
  // DIV: hi is the running remainder, lo shifts dividend out / quotient in.
  always_comb begin
    add_s = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    rem_s = {hi, lo[WIDTH-1]};
    rem_d = rem_s - {1'b0, b_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= a;
      b_q   <= b;
      div_q <= is_div;
      cnt   <= '0;
    end else if (step) begin
      cnt <= cnt + CW'(1);
      if (div_q) begin
        if (!rem_d[WIDTH]) begin
          hi <= rem_d[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= rem_s[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= add_s[WIDTH:1];
        lo <= {add_s[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/seq_alu.sv
// Registered ALU stage: single-cycle logic/arith ops, iterative MUL/DIV/MOD when
// SEQ_ALU_MULDIV_EN is defined. Results and flags hold until the next completed op.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [3:0]       opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outrest,
  output logic [4:0]       outflag
);

  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] sc_res;
  logic [4:0]       sc_flg;
  logic             c, v, e, is_iter;
  logic             idle, sc_take, fin;
  logic [WIDTH-1:0] md_res;
  logic [4:0]       md_flg;

  always_comb begin
    sum     = {1'b0, iA} + {1'b0, iB};
    dif     = {1'b0, iA} - {1'b0, iB};
    sc_res  = '0;
    c       = 1'b0;
    v       = 1'b0;
    e       = 1'b0;
    is_iter = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (iA[WIDTH-1] == iB[WIDTH-1]) && (sum[WIDTH-1] != iA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif[WIDTH-1:0];
        c      = dif[WIDTH];
        v      = (iA[WIDTH-1] != iB[WIDTH-1]) && (dif[WIDTH-1] != iA[WIDTH-1]);
      end
      OP_AND:   sc_res = iA & iB;
      OP_OR:    sc_res = iA | iB;
      OP_XOR:   sc_res = iA ^ iB;
      OP_NOT:   sc_res = ~iA;
      OP_SHL:   begin sc_res = {iA[WIDTH-2:0], 1'b0}; c = iA[WIDTH-1]; end
      OP_SHR:   begin sc_res = {1'b0, iA[WIDTH-1:1]}; c = iA[0];       end
      OP_INC:   begin sc_res = iA + WIDTH'(1); c = &iA;                end
      OP_DEC:   begin sc_res = iA - WIDTH'(1); c = (iA == '0);         end
      OP_PASSA: sc_res = iA;
      OP_PASSB: sc_res = iB;
`ifdef SEQ_ALU_MULDIV_EN
      OP_MUL:   is_iter = 1'b1;
      OP_DIV, OP_MOD: begin
        if (iB == '0) e = 1'b1;
        else          is_iter = 1'b1;
      end
`endif
      default:  e = 1'b1;
    endcase
    sc_flg = '0;
    sc_flg[FLG_Z] = (sc_res == '0);
    sc_flg[FLG_C] = c;
    sc_flg[FLG_N] = sc_res[WIDTH-1];
    sc_flg[FLG_V] = v;
    sc_flg[FLG_E] = e;
  end

`ifdef SEQ_ALU_MULDIV_EN
  state_t           state, state_nxt;
  logic             load, step, last;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] hi, lo;

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (opcode != OP_MUL),
    .a      (iA),
    .b      (iB),
    .last   (last),
    .hi     (hi),
    .lo     (lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (load) op_q <= opcode;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      ST_IDLE: if (start && is_iter) begin
        load      = 1'b1;
        state_nxt = ST_ITER;
      end
      ST_ITER: begin
        step = 1'b1;
        if (last) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        fin       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    md_res = (op_q == OP_MOD) ? hi : lo;
    md_flg = '0;
    md_flg[FLG_Z] = (md_res == '0);
    md_flg[FLG_C] = (op_q == OP_MUL) && (hi != '0);
    md_flg[FLG_N] = md_res[WIDTH-1];
  end

  assign idle = (state == ST_IDLE);
  assign busy = !idle;
`else
  assign idle   = 1'b1;
  assign busy   = 1'b0;
  assign fin    = 1'b0;
  assign md_res = '0;
  assign md_flg = '0;
`endif

  assign sc_take = idle && start && !is_iter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outrest <= '0;
      outflag <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sc_take) begin
        outrest <= sc_res;
        outflag <= sc_flg;
        done    <= 1'b1;
      end else if (fin) begin
        outrest <= md_res;
        outflag <= md_flg;
        done    <= 1'b1;
      end
    end
  end

endmodule
